// File: rtl/simon_decrypt_control_if.sv
// Request/response bundle between a SIMON 32/64 decryption controller and its requester.
// The master drives the request side (cipher, key, newData, newKey); the slave answers.
interface simon_decrypt_control_if #(
  parameter int N = 16,
  parameter int M = 4
);
  logic           newData;
  logic           newKey;
  logic           ldData;
  logic           ldKey;
  logic           doneData;
  logic           doneKey;
  logic [2*N-1:0] cipher;
  logic [M*N-1:0] key;
  logic [2*N-1:0] plain;

  modport master (
    output newData, newKey, cipher, key,
    input  ldData, ldKey, doneData, doneKey, plain
  );

  modport slave (
    input  newData, newKey, cipher, key,
    output ldData, ldKey, doneData, doneKey, plain
  );
endinterface

// File: rtl/simon_decrypt_control.sv
// Iterative SIMON 32/64 decryption: expands the key into a round-key store, then runs rounds T-1..0.
// Define SIMON_DEC_KEYCACHE_EN to keep the round-key store across requests (newKey=0 skips expansion).
module simon_decrypt_control #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter int C = 5
) (
  input logic                   clk,
  input logic                   nR,
  simon_decrypt_control_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} stateT;

`ifdef SIMON_DEC_KEYCACHE_EN
  localparam bit KEY_CACHE = 1'b1;
`else
  localparam bit KEY_CACHE = 1'b0;
`endif

  localparam logic [N-1:0] ROUND_CONST = ~N'(3);
  localparam logic [61:0]  Z0          = {2{31'b1111101000100101011000011100110}};

  stateT          state, stateNext;
  logic [C-1:0]   count, countNext;
  logic [N-1:0]   x, y, xNext, yNext;
  logic [N-1:0]   window [M];
  logic [N-1:0]   windowNext [M];
  logic [N-1:0]   store [T];
  logic           storeWe;
  logic           ldDataReg, ldKeyReg, doneDataReg, doneKeyReg;
  logic           ldDataNext, ldKeyNext, doneDataNext, doneKeyNext;
  logic [2*N-1:0] plainReg, plainNext;
  logic           needExpand;
  logic           zBit;
  logic [N-1:0]   t, newTop, roundKey;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] roundF(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  assign bus.ldData   = ldDataReg;
  assign bus.ldKey    = ldKeyReg;
  assign bus.doneData = doneDataReg;
  assign bus.doneKey  = doneKeyReg;
  assign bus.plain    = plainReg;

  // Next-state logic: key schedule step, inverse round and the handshake outputs.
  always_comb begin
    stateNext    = state;
    countNext    = count;
    xNext        = x;
    yNext        = y;
    windowNext   = window;
    storeWe      = 1'b0;
    ldDataNext   = 1'b0;
    ldKeyNext    = 1'b0;
    doneDataNext = doneDataReg;
    doneKeyNext  = doneKeyReg;
    plainNext    = plainReg;

    needExpand = bus.newKey || !doneKeyReg || !KEY_CACHE;
    zBit       = 1'((Z0 << count) >> 61);
    t          = ror(window[M-1], 3) ^ window[1];
    newTop     = ROUND_CONST ^ {{(N-1){1'b0}}, zBit} ^ window[0] ^ t ^ ror(t, 1);
    roundKey   = store[count];

    case (state)
      IDLE: begin
        if (bus.newData) begin
          xNext        = bus.cipher[2*N-1:N];
          yNext        = bus.cipher[N-1:0];
          ldDataNext   = 1'b1;
          doneDataNext = 1'b0;
          if (needExpand) begin
            for (int i = 0; i < M; i++) windowNext[i] = bus.key[i*N +: N];
            ldKeyNext   = 1'b1;
            doneKeyNext = 1'b0;
            countNext   = '0;
            stateNext   = EXPAND;
          end else begin
            countNext = C'(T - 1);
            stateNext = DECRYPT;
          end
        end
      end
      EXPAND: begin
        storeWe = 1'b1;
        for (int i = 0; i < M - 1; i++) windowNext[i] = window[i+1];
        windowNext[M-1] = newTop;
        if (count == C'(T - 1)) begin
          doneKeyNext = 1'b1;
          stateNext   = DECRYPT;
        end else begin
          countNext = count + 1'b1;
        end
      end
      DECRYPT: begin
        xNext = y;
        yNext = x ^ roundF(y) ^ roundKey;
        if (count == '0) stateNext = DONE;
        else             countNext = count - 1'b1;
      end
      DONE: begin
        plainNext    = {x, y};
        doneDataNext = 1'b1;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any operation and invalidates the key store.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state       <= IDLE;
      count       <= '0;
      x           <= '0;
      y           <= '0;
      window      <= '{default: '0};
      ldDataReg   <= 1'b0;
      ldKeyReg    <= 1'b0;
      doneDataReg <= 1'b0;
      doneKeyReg  <= 1'b0;
      plainReg    <= '0;
    end else begin
      state       <= stateNext;
      count       <= countNext;
      x           <= xNext;
      y           <= yNext;
      window      <= windowNext;
      ldDataReg   <= ldDataNext;
      ldKeyReg    <= ldKeyNext;
      doneDataReg <= doneDataNext;
      doneKeyReg  <= doneKeyNext;
      plainReg    <= plainNext;
    end
  end

  // Round-key store has no reset; its validity is tracked by doneKey.
  always_ff @(posedge clk) begin
    if (storeWe) store[count] <= window[0];
  end

endmodule

// File: tb/tb_simon_decrypt_control.sv
// Scoreboard bench for simon_decrypt_control: directed vectors plus encrypt/decrypt round trips.
module tb_simon_decrypt_control;
  localparam int N = 16;
  localparam int M = 4;
  localparam int T = 32;
  localparam int C = 5;

  localparam logic [63:0] TV_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] TV_CT  = 32'hC69BE9BB;
  localparam logic [31:0] TV_PT  = 32'h65656877;

  typedef struct {
    logic [31:0] plain;
    int          latency;
    logic        ldKey;
  } expT;

  logic clk = 1'b0;
  logic nR  = 1'b0;
  always #5 clk = ~clk;

  simon_decrypt_control_if #(.N(N), .M(M)) bus();

  simon_decrypt_control #(.N(N), .M(M), .T(T), .C(C)) dut (
    .clk (clk),
    .nR  (nR),
    .bus (bus.slave)
  );

  expT         sb[$];
  expT         monE;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          acceptCycle = 0;
  int          lastDoneCycle = 0;
  int          ldCount = 0;
  logic        prevDone = 1'b0;
  logic        keyValid = 1'b0;
  logic [63:0] lastKey = '0;
  logic [63:0] rk;
  logic [31:0] rpt;
  logic        rnk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  // Reference forward cipher used to build ciphertexts for the round trips.
  function automatic logic [31:0] simonEncrypt(input logic [63:0] k64, input logic [31:0] pt);
    logic [15:0] k [32];
    logic [61:0] z;
    logic [61:0] zs;
    logic [15:0] t, x, y, tmp;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = k64[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      zs   = z << (i - 4);
      t    = ror16(k[i-1], 3) ^ k[i-3];
      t    = t ^ ror16(t, 1);
      k[i] = ~k[i-4] ^ t ^ 16'd3 ^ {15'd0, zs[61]};
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x   = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ k[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ldData"},   32'(bus.ldData),   32'd0);
    checkOutput({tag, "_ldKey"},    32'(bus.ldKey),    32'd0);
    checkOutput({tag, "_doneData"}, 32'(bus.doneData), 32'd0);
    checkOutput({tag, "_doneKey"},  32'(bus.doneKey),  32'd0);
    checkOutput({tag, "_plain"},    bus.plain,         32'd0);
  endtask

  // Pushes the expected response, then holds newData until the request is accepted.
  task automatic applyStimulus(input logic [63:0] k, input logic [31:0] ct, input logic nk,
                               input logic [31:0] expPlain);
    expT  e;
    logic hit;
    logic seen;
`ifdef SIMON_DEC_KEYCACHE_EN
    hit = !nk && keyValid;
`else
    hit = 1'b0;
`endif
    e.plain   = expPlain;
    e.latency = hit ? T + 1 : 2 * T + 1;
    e.ldKey   = !hit;
    sb.push_back(e);
    if (!hit) begin
      keyValid = 1'b1;
      lastKey  = k;
    end
    bus.key     = k;
    bus.cipher  = ct;
    bus.newKey  = nk;
    bus.newData = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ldData;
    end
    bus.newData = 1'b0;
    bus.newKey  = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept: ldData not seen within 200 cycles, expected a pulse");
      void'(sb.pop_back());
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: checks ldKey on each accept and the full response on each doneData rise.
  always @(negedge clk) begin
    if (!nR) begin
      prevDone = 1'b0;
      ldCount  = 0;
    end else begin
      if (bus.ldData) begin
        ldCount++;
        acceptCycle = cycle;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL ldData: got unexpected pulse, expected none");
        end else begin
          checkOutput("ldKey", 32'(bus.ldKey), 32'(sb[0].ldKey));
        end
      end
      if (bus.doneData && !prevDone) begin
        lastDoneCycle = cycle;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL doneData: got unexpected rise, expected none");
        end else begin
          monE = sb.pop_front();
          checkOutput("plain",    bus.plain,                   monE.plain);
          checkOutput("latency",  32'(cycle - acceptCycle),    32'(monE.latency));
          checkOutput("ldPulses", 32'(ldCount),                32'd1);
          checkOutput("doneKey",  32'(bus.doneKey),            32'd1);
        end
        ldCount = 0;
      end
      prevDone = bus.doneData;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.newData = 1'b0;
    bus.newKey  = 1'b0;
    bus.cipher  = '0;
    bus.key     = '0;
    nR = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    nR = 1'b1;
    @(negedge clk);

    $display("[TB] published test vector with newKey=1");
    applyStimulus(TV_KEY, TV_CT, 1'b1, TV_PT);
    waitIdle();

    $display("[TB] same key with newKey=0");
    applyStimulus(TV_KEY, TV_CT, 1'b0, TV_PT);
    waitIdle();

    $display("[TB] back-to-back requests with newData held high");
    applyStimulus(TV_KEY, TV_CT, 1'b1, TV_PT);
    applyStimulus(TV_KEY, TV_CT, 1'b0, TV_PT);
    checkOutput("backToBackAccept", 32'(cycle - lastDoneCycle), 32'd1);
    waitIdle();

    $display("[TB] reset during decryption");
    applyStimulus(TV_KEY, TV_CT, 1'b1, TV_PT);
    repeat (52) @(negedge clk);
    nR = 1'b0;
    #1;
    checkReset("midReset");
    sb.delete();
    keyValid = 1'b0;
    @(negedge clk);
    nR = 1'b1;
    @(negedge clk);
    applyStimulus(TV_KEY, TV_CT, 1'b0, TV_PT);
    waitIdle();

    $display("[TB] random round trips");
    for (int i = 0; i < 100; i++) begin
      if (i % 4 == 3) begin
        rk  = lastKey;
        rnk = 1'b0;
      end else begin
        rk  = {$urandom, $urandom};
        rnk = 1'b1;
      end
      rpt = $urandom;
      applyStimulus(rk, simonEncrypt(rk, rpt), rnk, rpt);
    end
    waitIdle();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
